i2s_tx_stereo: RTL and testbench



---
 rtl/i2s_pkg.sv | 21 ++
 rtl/i2s_tx_shifter.sv | 36 +++
 rtl/i2s_tx_stereo.sv | 119 +++++++++++
 tb/tb_i2s_tx_stereo.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : i2s_pkg
// Brief    : Shared types, constants and helpers for the I2S transmitter.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package i2s_pkg;

    localparam int c_default_bits = 10;

    typedef logic [c_default_bits-1:0] sample_t;

    localparam logic c_ws_left  = 1'b0;
    localparam logic c_ws_right = 1'b1;

    function automatic int slot_cnt_width(input int slot_bits);
        return $clog2(2 * slot_bits);
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_tx_shifter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : i2s_tx_shifter
// Brief    : Per-channel parallel-load, MSB-first shift register, zero fill.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module i2s_tx_shifter #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_bit
);

    logic [WIDTH-1:0] r_sh;

    // Load together with shift emits the MSB on the load edge itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh <= '0;
        end else if (i_load && i_shift) begin
            r_sh <= i_data << 1;
        end else if (i_load) begin
            r_sh <= i_data;
        end else if (i_shift) begin
            r_sh <= r_sh << 1;
        end
    end

    assign o_bit = i_load ? i_data[WIDTH-1] : r_sh[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/i2s_tx_stereo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : i2s_tx_stereo
// Brief    : Stereo I2S transmitter with single-entry holding buffer.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module i2s_tx_stereo
    import i2s_pkg::*;
#(
    parameter int BITS_PRECISION = 10,
    parameter int SLOT_BITS      = 16
) (
    input  logic                      sck,
    input  logic                      rst,
    input  logic [BITS_PRECISION-1:0] data_left,
    input  logic [BITS_PRECISION-1:0] data_right,
    input  logic                      data_valid,
    output logic                      data_ready,
    output logic                      ws,
    output logic                      sd,
    output logic                      underrun
);

    localparam int                 c_cnt_w    = slot_cnt_width(SLOT_BITS);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(2 * SLOT_BITS - 1);
    localparam logic [c_cnt_w-1:0] c_slot     = c_cnt_w'(SLOT_BITS);

    logic [c_cnt_w-1:0]        r_cnt;
    logic [c_cnt_w-1:0]        w_cnt_next;
    logic                      r_full;
    logic [BITS_PRECISION-1:0] r_buf_l;
    logic [BITS_PRECISION-1:0] r_buf_r;
    logic [BITS_PRECISION-1:0] w_load_l;
    logic [BITS_PRECISION-1:0] w_load_r;
    logic                      w_accept;
    logic                      w_load;
    logic                      w_left_phase;
    logic                      w_left_bit;
    logic                      w_right_bit;
    logic                      r_ws;
    logic                      r_sd;
    logic                      r_underrun;

    assign w_cnt_next   = (r_cnt == c_cnt_last) ? '0 : r_cnt + 1'b1;
    assign w_load       = (r_cnt == '0);
    assign w_accept     = data_valid && !r_full;
    // Edge from cnt=c emits slot position c, so c < SLOT_BITS drives the left slot.
    assign w_left_phase = (r_cnt < c_slot);
    assign w_load_l     = r_full ? r_buf_l : '0;
    assign w_load_r     = r_full ? r_buf_r : '0;

    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    // An accept on the load edge is stored, never bypassed into the shifters.
    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            r_full  <= 1'b0;
            r_buf_l <= '0;
            r_buf_r <= '0;
        end else begin
            if (w_accept) begin
                r_buf_l <= data_left;
                r_buf_r <= data_right;
            end
            if (w_load) begin
                r_full <= w_accept;
            end else if (w_accept) begin
                r_full <= 1'b1;
            end
        end
    end

    i2s_tx_shifter #(
        .WIDTH (BITS_PRECISION)
    ) u_shift_left (
        .clk     (sck),
        .rst     (rst),
        .i_load  (w_load),
        .i_shift (w_left_phase),
        .i_data  (w_load_l),
        .o_bit   (w_left_bit)
    );

    i2s_tx_shifter #(
        .WIDTH (BITS_PRECISION)
    ) u_shift_right (
        .clk     (sck),
        .rst     (rst),
        .i_load  (w_load),
        .i_shift (!w_left_phase),
        .i_data  (w_load_r),
        .o_bit   (w_right_bit)
    );

    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            r_ws       <= c_ws_left;
            r_sd       <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_ws       <= (w_cnt_next >= c_slot) ? c_ws_right : c_ws_left;
            r_sd       <= w_left_phase ? w_left_bit : w_right_bit;
            r_underrun <= w_load && !r_full;
        end
    end

    assign data_ready = ~r_full;
    assign ws         = r_ws;
    assign sd         = r_sd;
    assign underrun   = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx_stereo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_i2s_tx_stereo
// Brief    : Self-checking bench for i2s_tx_stereo (10/16 and 16/16 configs).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_i2s_tx_stereo;

    logic sck = 1'b0;
    always #5 sck = ~sck;

    logic       rst;
    logic [9:0] data_left, data_right;
    logic       data_valid, data_ready, ws, sd, underrun;

    i2s_tx_stereo #(.BITS_PRECISION(10), .SLOT_BITS(16)) u_dut (
        .sck(sck), .rst(rst), .data_left(data_left), .data_right(data_right),
        .data_valid(data_valid), .data_ready(data_ready), .ws(ws), .sd(sd),
        .underrun(underrun)
    );

    logic        m_rst;
    logic [15:0] m_left, m_right;
    logic        m_valid, m_ready, m_ws, m_sd, m_under;

    i2s_tx_stereo #(.BITS_PRECISION(16), .SLOT_BITS(16)) u_min (
        .sck(sck), .rst(m_rst), .data_left(m_left), .data_right(m_right),
        .data_valid(m_valid), .data_ready(m_ready), .ws(m_ws), .sd(m_sd),
        .underrun(m_under)
    );

    typedef struct { logic [9:0] l; logic [9:0] r; } pair_t;
    typedef struct { logic [31:0] sd; logic under; } frame_t;

    localparam logic [31:0] c_ws_word = 32'h0001_FFFE;

    int     n_checks = 0;
    int     n_pass   = 0;
    int     tb_cnt;
    int     ready_err;
    logic   m_full;
    pair_t  src[$];
    frame_t frames[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic apply_src();
        if (src.size() > 0) begin
            data_valid = 1'b1;
            data_left  = src[0].l;
            data_right = src[0].r;
        end else begin
            data_valid = 1'b0;
            data_left  = '0;
            data_right = '0;
        end
    endtask

    // One sck cycle; tracks the expected buffer flag and frame position.
    task automatic tick();
        logic acc, load;
        acc  = data_valid && !m_full;
        load = (tb_cnt == 0);
        @(posedge sck); #1;
        if (load) m_full = acc;
        else if (acc) m_full = 1'b1;
        if (acc) void'(src.pop_front());
        apply_src();
        tb_cnt = (tb_cnt == 31) ? 0 : tb_cnt + 1;
        if (data_ready !== !m_full) ready_err++;
    endtask

    // Bit 31 of each capture word is cnt=1, bit 0 is cnt=0 of the next frame.
    task automatic frame_check(input int idx, input frame_t f);
        logic [31:0] c_sd, c_ws, c_un;
        ready_err = 0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            c_sd[32-k] = sd;
            c_ws[32-k] = ws;
            c_un[32-k] = underrun;
        end
        check($sformatf("frame%0d.sd", idx), c_sd, f.sd);
        check($sformatf("frame%0d.ws", idx), c_ws, c_ws_word);
        check($sformatf("frame%0d.underrun", idx), c_un, {f.under, 31'b0});
        check($sformatf("frame%0d.ready_errors", idx), 32'(ready_err), 32'd0);
    endtask

    initial begin
        logic [31:0] w_sd, w_ws;

        frames[0]  = '{32'h0000_0000, 1'b1};
        frames[1]  = '{32'hAA80_5540, 1'b0};
        frames[2]  = '{32'hFFC0_0000, 1'b0};
        frames[3]  = '{32'h8000_0040, 1'b0};
        frames[4]  = '{32'h70C0_BC00, 1'b0};
        frames[5]  = '{32'h0000_FFC0, 1'b0};
        frames[6]  = '{32'h0000_0000, 1'b1};
        frames[7]  = '{32'h0000_0000, 1'b1};
        frames[8]  = '{32'h0000_0000, 1'b1};
        frames[9]  = '{32'h0000_0000, 1'b1};
        frames[10] = '{32'hFFC0_FFC0, 1'b0};
        frames[11] = '{32'h0000_0000, 1'b1};

        rst = 1'b1; m_rst = 1'b1;
        data_valid = 1'b0; data_left = '0; data_right = '0;
        m_valid = 1'b0; m_left = '0; m_right = '0;
        m_full = 1'b0; tb_cnt = 0; ready_err = 0;

        repeat (3) @(posedge sck);
        #1;
        check("reset.ws", 32'(ws), 32'd0);
        check("reset.sd", 32'(sd), 32'd0);
        check("reset.ready", 32'(data_ready), 32'd1);
        check("reset.underrun", 32'(underrun), 32'd0);

        src.push_back('{10'h2AA, 10'h155});
        apply_src();
        rst = 1'b0;

        for (int i = 0; i <= 10; i++) begin
            if (i == 1) begin
                src.push_back('{10'h3FF, 10'h000});
                src.push_back('{10'h200, 10'h001});
                src.push_back('{10'h1C3, 10'h2F0});
                src.push_back('{10'h000, 10'h3FF});
                apply_src();
            end
            if (i == 9) begin
                src.push_back('{10'h3FF, 10'h3FF});
                src.push_back('{10'h3FF, 10'h3FF});
                src.push_back('{10'h2AA, 10'h155});
                apply_src();
            end
            frame_check(i, frames[i]);
        end

        // Partial frame: reset lands mid left slot with a pair buffered.
        repeat (7) tick();
        check("prereset.sd", 32'(sd), 32'd1);
        check("prereset.ready", 32'(data_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("midreset.ws", 32'(ws), 32'd0);
        check("midreset.sd", 32'(sd), 32'd0);
        check("midreset.ready", 32'(data_ready), 32'd1);
        check("midreset.underrun", 32'(underrun), 32'd0);
        repeat (2) @(posedge sck);
        #1;
        src.delete();
        apply_src();
        m_full = 1'b0; tb_cnt = 0;
        rst = 1'b0;
        frame_check(11, frames[11]);

        m_left = 16'h8001; m_right = 16'h0000; m_valid = 1'b1;
        @(posedge sck); #1;
        m_rst = 1'b0;
        @(posedge sck); #1;
        m_valid = 1'b0;
        check("min.underrun", 32'(m_under), 32'd1);
        check("min.ready", 32'(m_ready), 32'd0);
        repeat (31) begin
            @(posedge sck); #1;
        end
        for (int k = 1; k <= 32; k++) begin
            @(posedge sck); #1;
            w_sd[32-k] = m_sd;
            w_ws[32-k] = m_ws;
        end
        check("min.sd", w_sd, 32'h8001_0000);
        check("min.ws", w_ws, c_ws_word);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
